mfp_ahb_arbiter_2m: RTL and testbench

MFP_AHB_ARBITER_2M -- requirements
Module: mfp_ahb_arbiter_2m

---
 rtl/mfp_ahb_arbiter_2m_pkg.sv | 11 +
 rtl/mfp_ahb_arbiter_2m_if.sv | 26 ++
 rtl/mfp_ahb_arb_req_latch.sv | 47 ++++
 rtl/mfp_ahb_arbiter_2m.sv | 138 +++++++++++++
 tb/tb_mfp_ahb_arbiter_2m.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mfp_ahb_arbiter_2m_pkg.sv
// Shared AHB-Lite transfer and burst codes for the two-master arbiter slice.
package mfp_ahb_arbiter_2m_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

endpackage

// File: rtl/mfp_ahb_arbiter_2m_if.sv
// One AHB-Lite port bundle; "master" is the side that issues transfers.
interface mfp_ahb_arbiter_2m_if;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic        HSEL;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HSEL, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HSEL, HWDATA,
        output HRDATA, HREADY, HRESP
    );

endinterface

// File: rtl/mfp_ahb_arb_req_latch.sv
// Per-master request holder: pending flag plus the captured address and controls
// of the transfer the master is waiting on.
module mfp_ahb_arb_req_latch #(
    parameter int ADDR_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              req,
    input  logic              hready,
    input  logic              done,
    input  logic [31:0]       haddr,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic              hmastlock,
    output logic              pending,
    output logic [ADDR_W-1:0] addr,
    output logic              write,
    output logic [2:0]        size,
    output logic              lock
);

    logic capture;

    assign capture = req & hready;

    // NOTE: non-blocking assignments so every register samples pre-edge values;
    // the captured fields are reset too because the lock bit steers arbitration.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pending <= 1'b0;
            addr    <= '0;
            write   <= 1'b0;
            size    <= 3'd0;
            lock    <= 1'b0;
        end else if (capture) begin
            // A new request in the completion cycle wins over the clear.
            pending <= 1'b1;
            addr    <= ADDR_W'(haddr);
            write   <= hwrite;
            size    <= hsize;
            lock    <= hmastlock;
        end else if (done) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/mfp_ahb_arbiter_2m.sv
// Two-master to one-slave AHB-Lite arbiter: requests are parked per master,
// then replayed to the slave as SINGLE transfers, one at a time.
module mfp_ahb_arbiter_2m
    import mfp_ahb_arbiter_2m_pkg::*;
#(
    parameter bit LOCK_EN = 1'b1,
    parameter int ADDR_W  = 32
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    mfp_ahb_arbiter_2m_if.slave  m0,
    mfp_ahb_arbiter_2m_if.slave  m1,
    mfp_ahb_arbiter_2m_if.master s,
    output logic                 grant
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        pending;
    logic [1:0]        lock;
    logic [1:0]        wr;
    logic [1:0]        done;
    logic [1:0]        hready;
    logic [ADDR_W-1:0] cap_addr [2];
    logic [2:0]        cap_size [2];
    logic              winner;
    logic              unused_ok;

    assign done[0] = (state == S_DATA) && !grant && s.HREADY;
    assign done[1] = (state == S_DATA) &&  grant && s.HREADY;
    assign hready  = ~pending | done;

    mfp_ahb_arb_req_latch #(.ADDR_W(ADDR_W)) u_req0 (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .req       (m0.HTRANS[1]),
        .hready    (hready[0]),
        .done      (done[0]),
        .haddr     (m0.HADDR),
        .hwrite    (m0.HWRITE),
        .hsize     (m0.HSIZE),
        .hmastlock (m0.HMASTLOCK),
        .pending   (pending[0]),
        .addr      (cap_addr[0]),
        .write     (wr[0]),
        .size      (cap_size[0]),
        .lock      (lock[0])
    );

    mfp_ahb_arb_req_latch #(.ADDR_W(ADDR_W)) u_req1 (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .req       (m1.HTRANS[1]),
        .hready    (hready[1]),
        .done      (done[1]),
        .haddr     (m1.HADDR),
        .hwrite    (m1.HWRITE),
        .hsize     (m1.HSIZE),
        .hmastlock (m1.HMASTLOCK),
        .pending   (pending[1]),
        .addr      (cap_addr[1]),
        .write     (wr[1]),
        .size      (cap_size[1]),
        .lock      (lock[1])
    );

    // Fair alternation, except a locked last grantee keeps the bus.
    // NOTE: default assigned first so no path through the block infers a latch.
    always_comb begin
        winner = grant;
        if (pending[0] && pending[1]) begin
            winner = (LOCK_EN && lock[grant]) ? grant : ~grant;
        end else if (pending[0]) begin
            winner = 1'b0;
        end else if (pending[1]) begin
            winner = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= S_IDLE;
            grant       <= 1'b1;
            s.HADDR     <= '0;
            s.HTRANS    <= HTRANS_IDLE;
            s.HSEL      <= 1'b0;
            s.HWRITE    <= 1'b0;
            s.HSIZE     <= 3'd0;
            s.HMASTLOCK <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|pending) begin
                        state       <= S_ADDR;
                        grant       <= winner;
                        s.HADDR     <= 32'(cap_addr[winner]);
                        s.HWRITE    <= wr[winner];
                        s.HSIZE     <= cap_size[winner];
                        s.HMASTLOCK <= lock[winner];
                        s.HTRANS    <= HTRANS_NONSEQ;
                        s.HSEL      <= 1'b1;
                    end
                end
                S_ADDR: begin
                    state    <= S_DATA;
                    s.HTRANS <= HTRANS_IDLE;
                    s.HSEL   <= 1'b0;
                end
                S_DATA: begin
                    if (s.HREADY) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign s.HBURST  = HBURST_SINGLE;
    assign s.HWDATA  = grant ? m1.HWDATA : m0.HWDATA;

    assign m0.HREADY = hready[0];
    assign m1.HREADY = hready[1];
    assign m0.HRDATA = s.HRDATA;
    assign m1.HRDATA = s.HRDATA;
    assign m0.HRESP  = (state == S_DATA) && !grant && s.HRESP;
    assign m1.HRESP  = (state == S_DATA) &&  grant && s.HRESP;

    // Master-side burst codes, HTRANS[0] and HSEL carry nothing this arbiter needs.
    assign unused_ok = &{1'b0, m0.HTRANS[0], m1.HTRANS[0], m0.HBURST, m1.HBURST,
                         m0.HSEL, m1.HSEL};

endmodule

// File: tb/tb_mfp_ahb_arbiter_2m.sv
// Bench for mfp_ahb_arbiter_2m: vector table, directed corner sequences and a
// randomized run against a transaction-level model.
module tb_mfp_ahb_arbiter_2m;
    import mfp_ahb_arbiter_2m_pkg::*;

    logic        HCLK;
    logic        HRESETn;
    logic        grant_a, grant_b;

    logic [1:0]  m_htrans [2];
    logic [31:0] m_haddr  [2];
    logic        m_hwrite [2];
    logic [2:0]  m_hsize  [2];
    logic        m_hlock  [2];
    logic [31:0] m_hwdata [2];
    logic [31:0] s_hrdata;
    logic        s_hready;
    logic        s_hresp;

    int n_tests = 0;
    int n_fail  = 0;

    mfp_ahb_arbiter_2m_if a_m0 ();
    mfp_ahb_arbiter_2m_if a_m1 ();
    mfp_ahb_arbiter_2m_if a_s ();
    mfp_ahb_arbiter_2m_if b_m0 ();
    mfp_ahb_arbiter_2m_if b_m1 ();
    mfp_ahb_arbiter_2m_if b_s ();

    assign a_m0.HADDR = m_haddr[0];   assign a_m0.HTRANS = m_htrans[0]; assign a_m0.HWRITE = m_hwrite[0];
    assign a_m0.HSIZE = m_hsize[0];   assign a_m0.HMASTLOCK = m_hlock[0]; assign a_m0.HWDATA = m_hwdata[0];
    assign a_m0.HBURST = 3'd0;        assign a_m0.HSEL = 1'b0;
    assign a_m1.HADDR = m_haddr[1];   assign a_m1.HTRANS = m_htrans[1]; assign a_m1.HWRITE = m_hwrite[1];
    assign a_m1.HSIZE = m_hsize[1];   assign a_m1.HMASTLOCK = m_hlock[1]; assign a_m1.HWDATA = m_hwdata[1];
    assign a_m1.HBURST = 3'd0;        assign a_m1.HSEL = 1'b0;
    assign b_m0.HADDR = m_haddr[0];   assign b_m0.HTRANS = m_htrans[0]; assign b_m0.HWRITE = m_hwrite[0];
    assign b_m0.HSIZE = m_hsize[0];   assign b_m0.HMASTLOCK = m_hlock[0]; assign b_m0.HWDATA = m_hwdata[0];
    assign b_m0.HBURST = 3'd0;        assign b_m0.HSEL = 1'b0;
    assign b_m1.HADDR = m_haddr[1];   assign b_m1.HTRANS = m_htrans[1]; assign b_m1.HWRITE = m_hwrite[1];
    assign b_m1.HSIZE = m_hsize[1];   assign b_m1.HMASTLOCK = m_hlock[1]; assign b_m1.HWDATA = m_hwdata[1];
    assign b_m1.HBURST = 3'd0;        assign b_m1.HSEL = 1'b0;
    assign a_s.HRDATA = s_hrdata;     assign a_s.HREADY = s_hready;     assign a_s.HRESP = s_hresp;
    assign b_s.HRDATA = s_hrdata;     assign b_s.HREADY = s_hready;     assign b_s.HRESP = s_hresp;

    mfp_ahb_arbiter_2m #(.LOCK_EN(1'b1), .ADDR_W(32)) dut_a (
        .HCLK(HCLK), .HRESETn(HRESETn), .m0(a_m0), .m1(a_m1), .s(a_s), .grant(grant_a)
    );

    mfp_ahb_arbiter_2m #(.LOCK_EN(1'b0), .ADDR_W(32)) dut_b (
        .HCLK(HCLK), .HRESETn(HRESETn), .m0(b_m0), .m1(b_m1), .s(b_s), .grant(grant_b)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic to_drive();
        @(posedge HCLK);
        #1;
    endtask

    task automatic to_check();
        @(negedge HCLK);
    endtask

    task automatic all_idle();
        for (int i = 0; i < 2; i++) begin
            m_htrans[i] = HTRANS_IDLE; m_haddr[i] = 32'h0; m_hwrite[i] = 1'b0;
            m_hsize[i]  = 3'd2;        m_hlock[i] = 1'b0;  m_hwdata[i] = 32'h0;
        end
        s_hrdata = 32'h0; s_hready = 1'b1; s_hresp = 1'b0;
    endtask

    // ---------------- transaction-level reference model ----------------
    localparam bit MODEL_LOCK = 1'b1;

    bit          md_has  [2];
    logic [31:0] md_addr [2];
    bit          md_wr   [2];
    logic [2:0]  md_size [2];
    bit          md_lock [2];
    bit          md_active;
    int          md_addr_cyc;
    bit          md_owner, md_last;
    logic [31:0] md_haddr;
    bit          md_hwrite;
    logic [2:0]  md_hsize;
    bit          md_hlock;
    int          cyc;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            md_has[i] = 1'b0; md_addr[i] = 32'h0; md_wr[i] = 1'b0; md_size[i] = 3'd0; md_lock[i] = 1'b0;
        end
        md_active = 1'b0; md_addr_cyc = -1; md_owner = 1'b1; md_last = 1'b1;
        md_haddr = 32'h0; md_hwrite = 1'b0; md_hsize = 3'd0; md_hlock = 1'b0;
        cyc = 0;
    endtask

    // Compare this cycle's outputs, then apply what the coming edge does.
    task automatic model_step();
        bit pa, pd, fin, w;
        bit er [2];
        logic [63:0] exp_v, act_v;
        pa = md_active && (cyc == md_addr_cyc);
        pd = md_active && (cyc > md_addr_cyc);
        for (int i = 0; i < 2; i++)
            er[i] = !md_has[i] || (pd && int'(md_owner) == i && s_hready);
        exp_v = 64'({er[0], er[1], (pa ? HTRANS_NONSEQ : HTRANS_IDLE), pa, md_last,
                     pd && !md_owner && s_hresp, pd && md_owner && s_hresp,
                     md_haddr, md_hwrite, md_hsize, md_hlock});
        act_v = 64'({a_m0.HREADY, a_m1.HREADY, a_s.HTRANS, a_s.HSEL, grant_a,
                     a_m0.HRESP, a_m1.HRESP, a_s.HADDR, a_s.HWRITE, a_s.HSIZE, a_s.HMASTLOCK});
        check($sformatf("rand_out_c%0d", cyc), act_v, exp_v);
        check($sformatf("rand_wdata_c%0d", cyc), 64'(a_s.HWDATA), 64'(m_hwdata[md_last]));
        if (pd)
            check($sformatf("rand_rdata_c%0d", cyc),
                  64'(md_owner ? a_m1.HRDATA : a_m0.HRDATA), 64'(s_hrdata));

        fin = pd && s_hready;
        if (!md_active && (md_has[0] || md_has[1])) begin
            if (md_has[0] && md_has[1])
                w = (MODEL_LOCK && md_lock[md_last]) ? md_last : !md_last;
            else
                w = md_has[1];
            md_active = 1'b1; md_addr_cyc = cyc + 1; md_owner = w; md_last = w;
            md_haddr = md_addr[w]; md_hwrite = md_wr[w]; md_hsize = md_size[w]; md_hlock = md_lock[w];
        end else if (fin) begin
            md_active = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (m_htrans[i][1] && er[i]) begin
                md_has[i] = 1'b1; md_addr[i] = m_haddr[i]; md_wr[i] = m_hwrite[i];
                md_size[i] = m_hsize[i]; md_lock[i] = m_hlock[i];
            end else if (fin && int'(md_owner) == i) begin
                md_has[i] = 1'b0;
            end
        end
        cyc++;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  t0, t1;
        logic        rdy, resp;
        logic [1:0]  e_rdy;   // {m0, m1}
        logic [1:0]  e_tr;
        logic        e_grant;
        logic [1:0]  e_resp;  // {m0, m1}
        logic [31:0] e_haddr;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vt [NVEC];

    int hi_cnt;

    initial begin
        // Both request after reset, then m0 alone, then m1 (SEQ) with an error.
        vt[0]  = '{2'b10, 2'b10, 1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 32'h0};
        vt[1]  = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 32'h0};
        vt[2]  = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 2'b00, 32'h10};
        vt[3]  = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 32'h10};
        vt[4]  = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 32'h10};
        vt[5]  = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b10, 2'b10, 1'b1, 2'b00, 32'h20};
        vt[6]  = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 32'h20};
        vt[7]  = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 32'h20};
        vt[8]  = '{2'b10, 2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 32'h20};
        vt[9]  = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 2'b00, 32'h20};
        vt[10] = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b01, 2'b10, 1'b0, 2'b00, 32'h10};
        vt[11] = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 32'h10};
        vt[12] = '{2'b00, 2'b11, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 32'h10};
        vt[13] = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 32'h10};
        vt[14] = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b10, 2'b10, 1'b1, 2'b00, 32'h20};
        vt[15] = '{2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1, 2'b01, 32'h20};
        vt[16] = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b11, 2'b00, 1'b1, 2'b01, 32'h20};
        vt[17] = '{2'b01, 2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 32'h20};
        vt[18] = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 32'h20};

        all_idle();
        HRESETn = 1'b0;
        m_haddr[0] = 32'h10; m_haddr[1] = 32'h20;
        to_drive();
        to_check();
        check("reset_a", 64'({a_m0.HREADY, a_m1.HREADY, a_s.HTRANS, a_s.HSEL, grant_a, a_m0.HRESP, a_m1.HRESP, a_s.HADDR}),
              64'({1'b1, 1'b1, HTRANS_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0}));
        check("reset_b", 64'({b_m0.HREADY, b_m1.HREADY, b_s.HTRANS, b_s.HSEL, grant_b}),
              64'({1'b1, 1'b1, HTRANS_IDLE, 1'b0, 1'b1}));

        to_drive();
        HRESETn = 1'b1;
        for (int r = 0; r < NVEC; r++) begin
            if (r != 0) to_drive();
            m_htrans[0] = vt[r].t0; m_htrans[1] = vt[r].t1;
            s_hready = vt[r].rdy;   s_hresp = vt[r].resp;
            to_check();
            check($sformatf("vec%0d", r),
                  64'({a_m0.HREADY, a_m1.HREADY, a_s.HTRANS, a_s.HSEL, grant_a, a_m0.HRESP, a_m1.HRESP, a_s.HADDR}),
                  64'({vt[r].e_rdy, vt[r].e_tr, (vt[r].e_tr == HTRANS_NONSEQ), vt[r].e_grant, vt[r].e_resp, vt[r].e_haddr}));
        end

        // m1 write held off by three slave wait states.
        to_drive();
        m_htrans[1] = HTRANS_NONSEQ; m_haddr[1] = 32'h30; m_hwrite[1] = 1'b1; m_hwdata[1] = 32'hCAFE_F00D;
        to_check();
        to_drive(); m_htrans[1] = HTRANS_IDLE;
        to_check(); check("wait_pend_rdy", 64'(a_m1.HREADY), 64'(0));
        to_drive();
        to_check(); check("wait_addr", 64'({a_s.HTRANS, a_s.HWRITE, a_s.HADDR, a_m1.HREADY}),
                          64'({HTRANS_NONSEQ, 1'b1, 32'h30, 1'b0}));
        hi_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            to_drive(); s_hready = (k == 3);
            to_check();
            check($sformatf("wait_wdata%0d", k), 64'(a_s.HWDATA), 64'(32'hCAFE_F00D));
            check($sformatf("wait_rdy%0d", k), 64'(a_m1.HREADY), 64'(k == 3));
            if (a_m1.HREADY) hi_cnt++;
        end
        check("wait_rdy_count", 64'(hi_cnt), 64'(1));
        to_drive(); s_hready = 1'b1; m_hwrite[1] = 1'b0;
        to_check();

        // Locked m0 re-requests in its completion cycle while m1 waits.
        to_drive(); m_htrans[0] = HTRANS_NONSEQ; m_haddr[0] = 32'h40; m_hlock[0] = 1'b1;
        to_check();
        to_drive(); m_htrans[0] = HTRANS_IDLE;
        to_check();
        to_drive(); m_htrans[1] = HTRANS_NONSEQ; m_haddr[1] = 32'h50;
        to_check(); check("lock_first_grant", 64'({grant_a, grant_b}), 64'(2'b00));
        to_drive(); m_htrans[0] = HTRANS_NONSEQ; m_haddr[0] = 32'h44;
        to_check(); check("lock_m0_done", 64'({a_m0.HREADY, b_m0.HREADY}), 64'(2'b11));
        to_drive(); m_htrans[0] = HTRANS_IDLE; m_htrans[1] = HTRANS_IDLE; m_hlock[0] = 1'b0;
        to_check();
        to_drive();
        to_check();
        check("lock_en1_regrant", 64'({grant_a, a_s.HADDR, a_s.HTRANS}), 64'({1'b0, 32'h44, HTRANS_NONSEQ}));
        check("lock_en0_alternate", 64'({grant_b, b_s.HADDR, b_s.HTRANS}), 64'({1'b1, 32'h50, HTRANS_NONSEQ}));
        for (int k = 0; k < 8; k++) begin
            to_drive();
            to_check();
        end
        check("lock_drained", 64'({a_m0.HREADY, a_m1.HREADY, b_m0.HREADY, b_m1.HREADY}), 64'(4'hF));

        // Reset asserted in the middle of a data phase.
        to_drive(); m_htrans[0] = HTRANS_NONSEQ; m_haddr[0] = 32'h70;
        to_check();
        to_drive(); m_htrans[0] = HTRANS_IDLE;
        to_check();
        to_drive();
        to_check();
        to_drive(); s_hready = 1'b0;
        to_check(); check("rst_pre_data", 64'(a_m0.HREADY), 64'(0));
        #1 HRESETn = 1'b0;
        #1 check("rst_async", 64'({a_m0.HREADY, a_m1.HREADY, a_s.HTRANS, a_s.HSEL, a_s.HADDR, grant_a, a_m0.HRESP}),
                 64'({1'b1, 1'b1, HTRANS_IDLE, 1'b0, 32'h0, 1'b1, 1'b0}));
        to_drive(); HRESETn = 1'b1; s_hready = 1'b1;
        to_check(); check("rst_no_stale0", 64'({a_m0.HREADY, a_m1.HREADY, a_s.HTRANS}), 64'({2'b11, HTRANS_IDLE}));
        to_drive(); m_htrans[0] = HTRANS_NONSEQ; m_haddr[0] = 32'h90;
        to_check(); check("rst_no_stale1", 64'({a_m0.HREADY, a_s.HTRANS}), 64'({1'b1, HTRANS_IDLE}));
        to_drive(); m_htrans[0] = HTRANS_IDLE;
        to_check(); check("rst_req_pend", 64'(a_m0.HREADY), 64'(0));
        to_drive();
        to_check(); check("rst_req_addr", 64'({grant_a, a_s.HADDR, a_s.HTRANS}), 64'({1'b0, 32'h90, HTRANS_NONSEQ}));
        to_drive(); s_hrdata = 32'h1234_5678;
        to_check(); check("rst_req_done", 64'({a_m0.HREADY, a_m0.HRDATA}), 64'({1'b1, 32'h1234_5678}));

        // Randomized traffic against the model.
        to_drive(); HRESETn = 1'b0; all_idle();
        to_drive(); HRESETn = 1'b1;
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            if (n != 0) to_drive();
            for (int i = 0; i < 2; i++) begin
                m_htrans[i] = 2'($urandom_range(0, 3));
                m_haddr[i]  = $urandom();
                m_hwrite[i] = 1'($urandom_range(0, 1));
                m_hsize[i]  = 3'($urandom_range(0, 2));
                m_hlock[i]  = ($urandom_range(0, 3) == 0);
                m_hwdata[i] = $urandom();
            end
            s_hready = ($urandom_range(0, 3) != 0);
            s_hresp  = ($urandom_range(0, 7) == 0);
            s_hrdata = $urandom();
            to_check();
            model_step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
